// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and defaults for the stopwatch controller
package stopwatch_pkg;

  typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_STOP, SW_LAP} sw_state_t;

  localparam logic [3:0] SW_POINT_DEFAULT = 4'b0100;

endpackage

// File: rtl/stopwatch_ctrl_button_conditioner.sv
// rtl/stopwatch_ctrl_button_conditioner.sv - 2-FF synchronizer, debounce and press detector
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      // cnt tracks how long the synced value has disagreed with the accepted level
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level <= sync2;
          press <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mode FSM, lap freeze and display word generation
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0] POINT_MASK      = SW_POINT_DEFAULT,
  parameter bit         BLANK_LZ        = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic [15:0] digits_in,
  output logic        run,
  output logic        clear,
  output logic        lap_active,
  output logic [15:0] data_out,
  output logic [3:0]  digit_display,
  output logic [3:0]  digit_point
);

  sw_state_t   state;
  logic [15:0] hold;
  logic        start_press;
  logic        lap_press;
  logic        start_level;
  logic        lap_level;
  logic        unused_levels;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_start),
    .level   (start_level),
    .press   (start_press)
  );

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
    .clk     (clk),
    .reset_n (reset_n),
    .btn_raw (btn_lap),
    .level   (lap_level),
    .press   (lap_press)
  );

  assign unused_levels = start_level | lap_level;

  // start is tested first in every state, so a coincident lap press is dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SW_IDLE;
      run        <= 1'b0;
      clear      <= 1'b0;
      lap_active <= 1'b0;
      hold       <= '0;
      data_out   <= '0;
    end else begin
      clear    <= 1'b0;
      data_out <= lap_active ? hold : digits_in;
      case (state)
        SW_IDLE: begin
          if (start_press) begin
            state <= SW_RUN;
            run   <= 1'b1;
          end
        end
        SW_RUN: begin
          if (start_press) begin
            state <= SW_STOP;
            run   <= 1'b0;
          end else if (lap_press) begin
            state      <= SW_LAP;
            hold       <= digits_in;
            lap_active <= 1'b1;
          end
        end
        SW_LAP: begin
          if (start_press) begin
            state <= SW_STOP;
            run   <= 1'b0;
          end else if (lap_press) begin
            state      <= SW_RUN;
            lap_active <= 1'b0;
          end
        end
        SW_STOP: begin
          if (start_press) begin
            state      <= SW_RUN;
            run        <= 1'b1;
            lap_active <= 1'b0;
          end else if (lap_press) begin
            state      <= SW_IDLE;
            clear      <= 1'b1;
            lap_active <= 1'b0;
          end
        end
        default: state <= SW_IDLE;
      endcase
    end
  end

  assign digit_display = {~(BLANK_LZ && (data_out[15:12] == 4'd0)), 3'b111};
  assign digit_point   = POINT_MASK;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with window-based reference model
module tb_stopwatch_ctrl;

  localparam int D = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_start, btn_lap;
  logic [15:0] digits_in;
  logic        run, clear, lap_active;
  logic [15:0] data_out;
  logic [3:0]  digit_display, digit_point;

  int errors = 0;
  int checks = 0;
  int clear_seen = 0;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .POINT_MASK(4'b0100), .BLANK_LZ(1'b1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .btn_start     (btn_start),
    .btn_lap       (btn_lap),
    .digits_in     (digits_in),
    .run           (run),
    .clear         (clear),
    .lap_active    (lap_active),
    .data_out      (data_out),
    .digit_display (digit_display),
    .digit_point   (digit_point)
  );

  always #5 clk = ~clk;

  // reference model: button acceptance = last D synced samples agree and differ from the level
  int          m_st;
  logic        m_run, m_clear, m_lap;
  logic [15:0] m_hold, m_data;
  logic        s1 [2];
  logic        s2 [2];
  logic        lvl [2];
  logic        mp [2];
  logic        win0 [$];
  logic        win1 [$];

  task automatic m_reset();
    m_st = M_IDLE; m_run = 0; m_clear = 0; m_lap = 0; m_hold = 0; m_data = 0;
    for (int b = 0; b < 2; b++) begin
      s1[b] = 0; s2[b] = 0; lvl[b] = 0; mp[b] = 0;
    end
    win0.delete();
    win1.delete();
  endtask

  function automatic logic all_eq(input logic q [$], input logic v);
    if (q.size() != D) return 1'b0;
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [15:0] nd;
    logic raw [2];
    nd = m_lap ? m_hold : digits_in;
    m_clear = 0;
    if (mp[0]) begin
      if (m_st == M_IDLE)      begin m_st = M_RUN;  m_run = 1; end
      else if (m_st == M_RUN)  begin m_st = M_STOP; m_run = 0; end
      else if (m_st == M_LAP)  begin m_st = M_STOP; m_run = 0; end
      else                     begin m_st = M_RUN;  m_run = 1; m_lap = 0; end
    end else if (mp[1]) begin
      if (m_st == M_RUN)       begin m_st = M_LAP; m_hold = digits_in; m_lap = 1; end
      else if (m_st == M_LAP)  begin m_st = M_RUN; m_lap = 0; end
      else if (m_st == M_STOP) begin m_st = M_IDLE; m_clear = 1; m_lap = 0; end
    end
    m_data = nd;
    raw[0] = btn_start;
    raw[1] = btn_lap;
    win0.push_back(s2[0]); if (win0.size() > D) void'(win0.pop_front());
    win1.push_back(s2[1]); if (win1.size() > D) void'(win1.pop_front());
    mp[0] = 0; mp[1] = 0;
    if (all_eq(win0, ~lvl[0])) begin lvl[0] = ~lvl[0]; mp[0] = lvl[0]; end
    if (all_eq(win1, ~lvl[1])) begin lvl[1] = ~lvl[1]; mp[1] = lvl[1]; end
    for (int b = 0; b < 2; b++) begin
      s2[b] = s1[b];
      s1[b] = raw[b];
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_model(input string name);
    logic [26:0] act, exp;
    act = {run, clear, lap_active, data_out, digit_display, digit_point};
    exp = {m_run, m_clear, m_lap, m_data,
           (m_data[15:12] == 4'd0) ? 4'b0111 : 4'b1111, 4'b0100};
    chk(name, {5'd0, act}, {5'd0, exp});
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    if (clear === 1'b1) clear_seen++;
    cmp_model("model");
  endtask

  task automatic press(input logic s, input logic l, input logic [15:0] d);
    btn_start = s; btn_lap = l; digits_in = d;
    repeat (9) cyc();
    btn_start = 0; btn_lap = 0;
    repeat (9) cyc();
  endtask

  typedef struct {
    logic        s;
    logic        l;
    logic [15:0] d;
    logic        er;
    logic        el;
    logic [15:0] ed;
    int          eclr;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'h1234, 0};
    tbl[1]  = '{1'b0, 1'b0, 16'h1240, 1'b1, 1'b1, 16'h1234, 0};
    tbl[2]  = '{1'b0, 1'b1, 16'h1240, 1'b1, 1'b0, 16'h1240, 0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0055, 1'b0, 1'b0, 16'h0055, 0};
    tbl[4]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1};
    tbl[5]  = '{1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 16'h9999, 0};
    tbl[6]  = '{1'b0, 1'b1, 16'h0312, 1'b1, 1'b1, 16'h0312, 0};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0312, 0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 16'h0312, 0};
    tbl[9]  = '{1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, 16'h0002, 0};
    tbl[10] = '{1'b1, 1'b1, 16'h0777, 1'b0, 1'b0, 16'h0777, 0};
    tbl[11] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 1};
    tbl[12] = '{1'b0, 1'b1, 16'h4321, 1'b0, 1'b0, 16'h4321, 0};

    m_reset();
    reset_n = 0; btn_start = 0; btn_lap = 0; digits_in = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {5'd0, run, clear, lap_active, data_out, digit_display, digit_point},
        {5'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0111, 4'b0100});
    reset_n = 1;
    repeat (3) cyc();

    // bouncy start never reaches D stable cycles
    btn_start = 1; repeat (3) cyc();
    btn_start = 0; cyc();
    btn_start = 1; repeat (3) cyc();
    btn_start = 0; repeat (10) cyc();
    chk("bounce_no_press", {31'd0, run}, 32'd0);

    btn_start = 1;
    for (int n = 1; n <= 10; n++) begin
      cyc();
      if (n == 6) chk("debounce_run_c6", {31'd0, run}, 32'd0);
      if (n == 7) chk("debounce_run_c7", {31'd0, run}, 32'd1);
    end
    btn_start = 0; repeat (10) cyc();
    chk("held_single_press", {31'd0, run}, 32'd1);

    press(1, 0, 16'h0000);
    chk("startstop_run0", {31'd0, run}, 32'd0);
    press(1, 0, 16'h0000);
    chk("startstop_run1", {31'd0, run}, 32'd1);
    chk("startstop_no_clear", clear_seen, 0);

    for (int i = 0; i < 13; i++) begin
      int c0;
      c0 = clear_seen;
      press(tbl[i].s, tbl[i].l, tbl[i].d);
      chk($sformatf("tbl%0d_run", i), {31'd0, run}, {31'd0, tbl[i].er});
      chk($sformatf("tbl%0d_lap", i), {31'd0, lap_active}, {31'd0, tbl[i].el});
      chk($sformatf("tbl%0d_data", i), {16'd0, data_out}, {16'd0, tbl[i].ed});
      chk($sformatf("tbl%0d_disp", i), {28'd0, digit_display},
          {28'd0, (tbl[i].ed[15:12] == 4'd0) ? 4'b0111 : 4'b1111});
      chk($sformatf("tbl%0d_clears", i), clear_seen - c0, tbl[i].eclr);
    end

    // reset in the middle of LAP with a partially debounced start press
    press(1, 0, 16'h5678);
    press(0, 1, 16'h5678);
    chk("pre_reset_lap", {31'd0, lap_active}, 32'd1);
    btn_start = 1;
    repeat (2) cyc();
    #1 reset_n = 0;
    #1;
    chk("midreset_outputs", {5'd0, run, clear, lap_active, data_out, digit_display, digit_point},
        {5'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0111, 4'b0100});
    m_reset();
    repeat (3) cyc();
    reset_n = 1;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      if (n == 6) chk("post_reset_run_c6", {31'd0, run}, 32'd0);
      if (n == 7) chk("post_reset_run_c7", {31'd0, run}, 32'd1);
    end
    btn_start = 0; repeat (10) cyc();
    chk("post_reset_single", {31'd0, run}, 32'd1);

    // random buttons with varied dwell times and live digits
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      btn_start = 1'($urandom_range(0, 1));
      btn_lap   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        digits_in = 16'($urandom);
        if ($urandom_range(0, 2) == 0) digits_in[15:12] = 4'd0;
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
